dsp_add_cascade_chain: RTL and testbench

Parametrised, pipelined systolic adder chain. It sums `NUM_OPS` signed operands, each with its own unsigned compensate carry bit, plus an external cascade input. This is the carry correction for the low-segment overflow of SIMD 2x multipliers. It replaces hand-instantiated chains of single-stage cascade adders in the bicubic interpolation datapath. It adds valid tracking, a global stall, a full-width cascade output for chaining, and optional output saturation.

---
 rtl/dsp_add_cascade_chain.sv | 196 +++++++++++++++++++
 tb/tb_dsp_add_cascade_chain.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_add_cascade_chain.sv
// rtl/dsp_add_cascade_chain.sv - pipelined systolic cascade adder chain with carry compensation
//
// Sums NUM_OPS signed operands, each with an unsigned 0/1 compensate carry,
// plus a full-width cascade input. Every stage adds the operands that belong
// to one input beat, because operand k runs through a skew line of k registers.
// Latency is INREG + NUM_OPS + 1 enabled cycles; throughput is one beat per
// enabled cycle.
//
// Optional feature macro: DSP_ADD_CHAIN_SAT_EN. When it is defined, result
// saturates to the OUT_WIDTH signed range and sat_flag marks clamped beats.
// When it is undefined, result wraps and sat_flag is constant 0.
//
// Ports:
//   clk        - rising-edge clock
//   aresetn    - asynchronous active-low reset, clears every register
//   clken      - global clock enable; low freezes the whole pipeline
//   dsp_reset  - synchronous clear of all registers, priority over clken
//   in_valid   - operand set valid (sampled when clken=1)
//   op         - NUM_OPS signed operands, operand k at [k*IN_WIDTH +: IN_WIDTH]
//   cin        - NUM_OPS unsigned compensate carries
//   pc_in      - signed cascade input, sampled together with op
//   out_valid  - result/pc_out hold a valid beat
//   result     - narrowed final sum (wrapped or saturated)
//   pc_out     - full-width final sum, for chaining
//   sat_flag   - result was clamped on this beat
module dsp_add_cascade_chain #(
    parameter int NUM_OPS   = 4,
    parameter int IN_WIDTH  = 18,
    parameter int ACC_WIDTH = 48,
    parameter int OUT_WIDTH = 24,
    parameter int INREG     = 2
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          clken,
    input  logic                          dsp_reset,
    input  logic                          in_valid,
    input  logic [NUM_OPS*IN_WIDTH-1:0]   op,
    input  logic [NUM_OPS-1:0]            cin,
    input  logic [ACC_WIDTH-1:0]          pc_in,
    output logic                          out_valid,
    output logic [OUT_WIDTH-1:0]          result,
    output logic [ACC_WIDTH-1:0]          pc_out,
    output logic                          sat_flag
);

    // Skew lines are packed end to end in one triangular array: line k
    // (k >= 1) is k registers long and starts at entry k*(k-1)/2.
    localparam int SKEW_N = (NUM_OPS > 1) ? (NUM_OPS * (NUM_OPS - 1)) / 2 : 1;

    function automatic int skew_base(input int k);
        return (k * (k - 1)) / 2;
    endfunction

    // Input register stages
    logic [NUM_OPS*IN_WIDTH-1:0] in_op_q  [INREG];
    logic [NUM_OPS-1:0]          in_cin_q [INREG];
    logic [ACC_WIDTH-1:0]        in_pc_q  [INREG];
    logic [INREG-1:0]            in_vld_q;

    // Operand skew lines, each entry holds {cin, op}
    logic [IN_WIDTH:0]           skew_q   [SKEW_N];

    // Chain stage registers and their valid tags
    logic [ACC_WIDTH-1:0]        p_q      [NUM_OPS];
    logic [NUM_OPS-1:0]          vld_q;

    // Output register
    logic                        out_valid_q;
    logic [OUT_WIDTH-1:0]        result_q;
    logic [ACC_WIDTH-1:0]        pc_out_q;
    logic                        sat_q;

    // Next-state values
    logic [IN_WIDTH:0]           opc_in   [NUM_OPS];
    logic [IN_WIDTH:0]           opc_al   [NUM_OPS];
    logic [ACC_WIDTH-1:0]        p_d      [NUM_OPS];
    logic [ACC_WIDTH-1:0]        p_last;
    logic [OUT_WIDTH-1:0]        result_d;
    logic                        sat_d;

    always_comb begin
        // {cin, op} per operand as it leaves the last input register
        for (int k = 0; k < NUM_OPS; k++) begin
            opc_in[k] = {in_cin_q[INREG-1][k], in_op_q[INREG-1][k*IN_WIDTH +: IN_WIDTH]};
        end

        // Operand 0 feeds stage 0 directly; operand k arrives k cycles later
        opc_al[0] = opc_in[0];
        for (int k = 1; k < NUM_OPS; k++) begin
            opc_al[k] = skew_q[skew_base(k) + k - 1];
        end

        // Operand sign-extended, carry zero-extended, wrap in ACC_WIDTH
        p_d[0] = in_pc_q[INREG-1]
               + {{(ACC_WIDTH-IN_WIDTH){opc_al[0][IN_WIDTH-1]}}, opc_al[0][IN_WIDTH-1:0]}
               + {{(ACC_WIDTH-1){1'b0}}, opc_al[0][IN_WIDTH]};
        for (int k = 1; k < NUM_OPS; k++) begin
            p_d[k] = p_q[k-1]
                   + {{(ACC_WIDTH-IN_WIDTH){opc_al[k][IN_WIDTH-1]}}, opc_al[k][IN_WIDTH-1:0]}
                   + {{(ACC_WIDTH-1){1'b0}}, opc_al[k][IN_WIDTH]};
        end
    end

    assign p_last = p_q[NUM_OPS-1];

`ifdef DSP_ADD_CHAIN_SAT_EN
    // The value fits OUT_WIDTH exactly when every bit from OUT_WIDTH-1 up to
    // the sign bit agrees; otherwise clamp toward the sign of the full sum.
    logic [ACC_WIDTH-OUT_WIDTH:0] hi_bits;
    logic                         ovf;

    always_comb begin
        hi_bits = p_last[ACC_WIDTH-1:OUT_WIDTH-1];
        ovf     = !((&hi_bits) || !(|hi_bits));
        sat_d   = ovf;
        if (!ovf) begin
            result_d = p_last[OUT_WIDTH-1:0];
        end else if (p_last[ACC_WIDTH-1]) begin
            result_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            result_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end
`else
    always_comb begin
        result_d = p_last[OUT_WIDTH-1:0];
        sat_d    = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            in_op_q     <= '{default: '0};
            in_cin_q    <= '{default: '0};
            in_pc_q     <= '{default: '0};
            in_vld_q    <= '0;
            skew_q      <= '{default: '0};
            p_q         <= '{default: '0};
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            pc_out_q    <= '0;
            sat_q       <= 1'b0;
        end else if (dsp_reset) begin
            in_op_q     <= '{default: '0};
            in_cin_q    <= '{default: '0};
            in_pc_q     <= '{default: '0};
            in_vld_q    <= '0;
            skew_q      <= '{default: '0};
            p_q         <= '{default: '0};
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            pc_out_q    <= '0;
            sat_q       <= 1'b0;
        end else if (clken) begin
            in_op_q[0]  <= op;
            in_cin_q[0] <= cin;
            in_pc_q[0]  <= pc_in;
            in_vld_q[0] <= in_valid;
            for (int i = 1; i < INREG; i++) begin
                in_op_q[i]  <= in_op_q[i-1];
                in_cin_q[i] <= in_cin_q[i-1];
                in_pc_q[i]  <= in_pc_q[i-1];
                in_vld_q[i] <= in_vld_q[i-1];
            end

            for (int k = 1; k < NUM_OPS; k++) begin
                skew_q[skew_base(k)] <= opc_in[k];
                for (int j = 1; j < k; j++) begin
                    skew_q[skew_base(k) + j] <= skew_q[skew_base(k) + j - 1];
                end
            end

            for (int k = 0; k < NUM_OPS; k++) begin
                p_q[k] <= p_d[k];
            end
            vld_q[0] <= in_vld_q[INREG-1];
            for (int k = 1; k < NUM_OPS; k++) begin
                vld_q[k] <= vld_q[k-1];
            end

            out_valid_q <= vld_q[NUM_OPS-1];
            pc_out_q    <= p_last;
            result_q    <= result_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign pc_out    = pc_out_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_dsp_add_cascade_chain.sv
// tb/tb_dsp_add_cascade_chain.sv - self-checking bench for dsp_add_cascade_chain
module tb_dsp_add_cascade_chain;

    typedef struct packed {
        logic [3:0][17:0] op;
        logic [3:0]       cin;
        logic [47:0]      pc;
        logic [47:0]      exp_pc;
    } vec_t;

    typedef struct packed {
        logic [47:0] pc;
        logic [23:0] res;
        logic        sat;
        int          due;
    } sb_t;

    logic         clk = 1'b0;
    logic         aresetn, clken, dsp_reset;
    // default instance
    logic         in_valid;
    logic [71:0]  op;
    logic [3:0]   cin;
    logic [47:0]  pc_in;
    logic         out_valid, sat_flag;
    logic [23:0]  result;
    logic [47:0]  pc_out;
    // NUM_OPS=1, INREG=1 instance
    logic         iv1, ov1, sat1;
    logic [17:0]  op1;
    logic [0:0]   cin1;
    logic [47:0]  pc1, pcout1;
    logic [23:0]  res1;
    // NUM_OPS=8 instance
    logic         iv8, ov8, sat8;
    logic [143:0] op8;
    logic [7:0]   cin8;
    logic [47:0]  pc8, pcout8;
    logic [23:0]  res8;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   ecnt = 0;
    sb_t  q0[$];
    sb_t  q1[$];
    sb_t  q2[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    dsp_add_cascade_chain dut (
        .clk(clk), .aresetn(aresetn), .clken(clken), .dsp_reset(dsp_reset),
        .in_valid(in_valid), .op(op), .cin(cin), .pc_in(pc_in),
        .out_valid(out_valid), .result(result), .pc_out(pc_out), .sat_flag(sat_flag)
    );

    dsp_add_cascade_chain #(.NUM_OPS(1), .INREG(1)) dut1 (
        .clk(clk), .aresetn(aresetn), .clken(clken), .dsp_reset(dsp_reset),
        .in_valid(iv1), .op(op1), .cin(cin1), .pc_in(pc1),
        .out_valid(ov1), .result(res1), .pc_out(pcout1), .sat_flag(sat1)
    );

    dsp_add_cascade_chain #(.NUM_OPS(8)) dut8 (
        .clk(clk), .aresetn(aresetn), .clken(clken), .dsp_reset(dsp_reset),
        .in_valid(iv8), .op(op8), .cin(cin8), .pc_in(pc8),
        .out_valid(ov8), .result(res8), .pc_out(pcout8), .sat_flag(sat8)
    );

    function automatic vec_t mk(input int o0, input int o1, input int o2, input int o3,
                                input logic [3:0] c, input longint p, input longint e);
        vec_t v;
        v.op[0]  = o0[17:0];
        v.op[1]  = o1[17:0];
        v.op[2]  = o2[17:0];
        v.op[3]  = o3[17:0];
        v.cin    = c;
        v.pc     = p[47:0];
        v.exp_pc = e[47:0];
        return v;
    endfunction

    function automatic logic [47:0] add_op(input logic [47:0] acc, input logic [17:0] o, input logic c);
        return acc + {{30{o[17]}}, o} + {47'b0, c};
    endfunction

    function automatic sb_t mk_sb(input logic [47:0] p, input int due);
        sb_t e;
        e.pc  = p;
        e.due = due;
`ifdef DSP_ADD_CHAIN_SAT_EN
        if ($signed(p) > 48'sd8388607) begin
            e.res = 24'h7FFFFF; e.sat = 1'b1;
        end else if ($signed(p) < -48'sd8388608) begin
            e.res = 24'h800000; e.sat = 1'b1;
        end else begin
            e.res = p[23:0]; e.sat = 1'b0;
        end
`else
        e.res = p[23:0];
        e.sat = 1'b0;
`endif
        return e;
    endfunction

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check(input int id, input logic ov, input logic [23:0] r,
                         input logic [47:0] p, input logic s);
        sb_t e;
        bit  have;
        if (!ov) return;
        have = 1'b0;
        case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        n_cmp++;
        if (!have) begin
            n_fail++;
            $display("FAIL beat dut%0d: out_valid=1 but no beat expected (result=%0h pc_out=%0h)", id, r, p);
        end else if (r !== e.res || p !== e.pc || s !== e.sat || ecnt != e.due) begin
            n_fail++;
            $display("FAIL beat dut%0d: got result=%0h pc_out=%0h sat=%0b at cycle %0d, expected result=%0h pc_out=%0h sat=%0b at cycle %0d",
                     id, r, p, s, ecnt, e.res, e.pc, e.sat, e.due);
        end
    endtask

    // One clock: count the enabled edge, then check outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        if (aresetn && !dsp_reset && clken) ecnt++;
        @(negedge clk);
        check(0, out_valid, result, pc_out, sat_flag);
        check(1, ov1, res1, pcout1, sat1);
        check(2, ov8, res8, pcout8, sat8);
    endtask

    // Drive one beat for the next edge (assumed enabled) and queue expectations.
    task automatic drive(input vec_t v, input bit valid, input bit aux);
        logic [47:0] acc;
        op = v.op; cin = v.cin; pc_in = v.pc; in_valid = valid;
        op1 = v.op[0]; cin1[0] = v.cin[0]; pc1 = v.pc; iv1 = aux;
        for (int k = 0; k < 8; k++) begin
            op8[k*18 +: 18] = v.op[k%4];
            cin8[k] = v.cin[k%4];
        end
        pc8 = v.pc; iv8 = aux;
        if (valid) q0.push_back(mk_sb(v.exp_pc, ecnt + 7));
        if (aux) begin
            acc = add_op(v.pc, v.op[0], v.cin[0]);
            q1.push_back(mk_sb(acc, ecnt + 3));
            acc = v.pc;
            for (int k = 0; k < 8; k++) acc = add_op(acc, v.op[k%4], v.cin[k%4]);
            q2.push_back(mk_sb(acc, ecnt + 11));
        end
    endtask

    initial begin
        vec_t zero_v, idle3, stall_v;
        zero_v  = mk(0, 0, 0, 0, 4'b0000, 0, 0);
        idle3   = mk(3, 0, 0, 0, 4'b0000, 0, 3);
        stall_v = mk(5, 6, 7, 8, 4'b0000, 0, 26);

        tbl.push_back(mk(1, 2, 3, 4, 4'b1010, 100, 112));
        for (int n = 0; n < 10; n++) tbl.push_back(mk(n, 0, 0, 0, 4'b0000, 0, n));
        tbl.push_back(mk(-131072, -131072, -131072, -131072, 4'b1111, 0, -524284));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 8388607, 8388608));
        tbl.push_back(mk(-1, 0, 0, 0, 4'b0000, -8388608, -8388609));
        tbl.push_back(mk(131071, 131071, 131071, 131071, 4'b1111, 0, 524288));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 64'sd140737488355327, -64'sd140737488355328));

        aresetn = 1'b0; clken = 1'b1; dsp_reset = 1'b0;
        drive(zero_v, 1'b0, 1'b0);
        step(); step();
        expect_eq("reset_out_valid", {63'b0, out_valid}, 64'd0);
        expect_eq("reset_result", {40'b0, result}, 64'd0);
        expect_eq("reset_pc_out", {16'b0, pc_out}, 64'd0);
        expect_eq("reset_sat_flag", {63'b0, sat_flag}, 64'd0);
        aresetn = 1'b1;

        // Single pulse: 112 after 7 cycles, exactly once
        drive(tbl[0], 1'b1, 1'b0);
        step();
        for (int i = 0; i < 12; i++) begin drive(zero_v, 1'b0, 1'b0); step(); end
        expect_eq("basic_drained", q0.size(), 0);

        // Back-to-back table into all three instances
        for (int i = 0; i < tbl.size(); i++) begin drive(tbl[i], 1'b1, 1'b1); step(); end
        for (int i = 0; i < 14; i++) begin drive(zero_v, 1'b0, 1'b0); step(); end
        expect_eq("stream_drained_dut", q0.size(), 0);
        expect_eq("stream_drained_dut1", q1.size(), 0);
        expect_eq("stream_drained_dut8", q2.size(), 0);

        // Stall for 3 cycles at cycle 3 of a beat; nothing moves meanwhile
        drive(stall_v, 1'b1, 1'b0);
        step();
        drive(zero_v, 1'b0, 1'b0);
        step(); step();
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_eq("stall_out_valid", {63'b0, out_valid}, 64'd0);
            expect_eq("stall_pc_out", {16'b0, pc_out}, 64'd0);
        end
        clken = 1'b1;
        for (int i = 0; i < 8; i++) step();
        expect_eq("stall_drained", q0.size(), 0);

        // dsp_reset with clken=0 kills an in-flight beat and clears outputs
        drive(tbl[0], 1'b1, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin drive(idle3, 1'b0, 1'b0); step(); end
        expect_eq("idle_data_pc_out", {16'b0, pc_out}, 64'd3);
        drive(tbl[11], 1'b1, 1'b0);
        step();
        drive(idle3, 1'b0, 1'b0);
        step(); step(); step();
        clken = 1'b0; dsp_reset = 1'b1;
        void'(q0.pop_back());
        step();
        expect_eq("dsp_reset_out_valid", {63'b0, out_valid}, 64'd0);
        expect_eq("dsp_reset_pc_out", {16'b0, pc_out}, 64'd0);
        expect_eq("dsp_reset_result", {40'b0, result}, 64'd0);
        dsp_reset = 1'b0; clken = 1'b1;
        drive(zero_v, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step();
        expect_eq("dsp_reset_quiet_pc_out", {16'b0, pc_out}, 64'd0);

        // Asynchronous reset mid-stream, then a clean beat at L=7
        for (int i = 0; i < 8; i++) begin drive(idle3, 1'b0, 1'b0); step(); end
        drive(tbl[1], 1'b1, 1'b0); step();
        drive(tbl[2], 1'b1, 1'b0); step();
        drive(idle3, 1'b0, 1'b0);
        step(); step(); step();
        #3 aresetn = 1'b0;
        #1;
        expect_eq("areset_out_valid", {63'b0, out_valid}, 64'd0);
        expect_eq("areset_pc_out", {16'b0, pc_out}, 64'd0);
        expect_eq("areset_result", {40'b0, result}, 64'd0);
        q0.delete(); q1.delete(); q2.delete();
        step(); step();
        aresetn = 1'b1;
        drive(tbl[0], 1'b1, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin drive(zero_v, 1'b0, 1'b0); step(); end
        expect_eq("areset_recovery_drained", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
